idexm_buffer: RTL and testbench

- Pipeline boundary register between the decode stage and the execute-memory stage; every control and data input of the execute-memory stage is driven from here.
- Performs three jobs:
  - assembles two-word instructions (opcode word, then a 16-bit immediate word);
  - detects load-use hazards and inserts one bubble for each;
  - squashes the in-flight instruction on a branch flush.

---
 rtl/idexm_buffer.sv | 194 +++++++++++++++++++
 tb/tb_idexm_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idexm_buffer.sv
// Decode to execute-memory pipeline register: two-word instruction assembly,
// load-use bubble insertion and branch-flush squash.
//
// state    | meaning
// NORMAL   | capturing one-word instructions, hazard check active
// WAIT_IMM | opcode word held, waiting for the trailing immediate word
module idexm_buffer #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_in_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_write_back,
  input  logic              i_imm,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [2:0]        i_rs,
  input  logic [2:0]        i_rt,
  input  logic              i_rs_used,
  input  logic              i_rt_used,
  input  logic [2:0]        i_write_addr,
  input  logic [DATA_W-1:0] i_fetch_word,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_write_back,
  output logic              o_imm,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [2:0]        o_rs,
  output logic [2:0]        o_write_addr,
  output logic [DATA_W-1:0] o_immediate,
  output logic              o_hold_upstream
);

  typedef enum logic [0:0] {NORMAL, WAIT_IMM} state_t;

  state_t r_state, w_state_nxt;

  logic [CTRL_W-1:0] r_h_ctrl;
  logic              r_h_mem_read, r_h_mem_write, r_h_write_back;
  logic [DATA_W-1:0] r_h_data1, r_h_data2;
  logic [2:0]        r_h_rs, r_h_write_addr;

  logic              r_valid, r_mem_read, r_mem_write, r_write_back, r_imm;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data1, r_data2, r_immediate;
  logic [2:0]        r_rs, r_write_addr;

  logic              w_loaduse, w_cap_hold, w_load_out;
  logic              w_valid, w_mem_read, w_mem_write, w_write_back, w_imm;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_data1, w_data2, w_immediate;
  logic [2:0]        w_rs, w_write_addr;

  // Only checked on entry in NORMAL; the immediate word of a two-word op reads no registers.
  assign w_loaduse = r_valid & r_mem_read & r_write_back & i_in_valid & (r_state == NORMAL) &
                     ((i_rs_used & (i_rs == r_write_addr)) | (i_rt_used & (i_rt == r_write_addr)));

  assign o_hold_upstream = ~i_flush & (i_stall | w_loaduse);

  always_comb begin
    w_state_nxt  = r_state;
    w_cap_hold   = 1'b0;
    w_load_out   = 1'b1;
    w_valid      = 1'b0;
    w_ctrl       = '0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_write_back = 1'b0;
    w_imm        = 1'b0;
    w_data1      = '0;
    w_data2      = '0;
    w_rs         = '0;
    w_write_addr = '0;
    w_immediate  = '0;
    if (i_flush) begin
      w_state_nxt = NORMAL;
    end else if (i_stall) begin
      w_load_out = 1'b0;
    end else if (!w_loaduse) begin
      case (r_state)
        NORMAL: begin
          if (i_in_valid && !i_imm) begin
            w_valid      = 1'b1;
            w_ctrl       = i_ctrl;
            w_mem_read   = i_mem_read;
            w_mem_write  = i_mem_write;
            w_write_back = i_write_back;
            w_data1      = i_data1;
            w_data2      = i_data2;
            w_rs         = i_rs;
            w_write_addr = i_write_addr;
          end else if (i_in_valid && i_imm) begin
            w_cap_hold  = 1'b1;
            w_state_nxt = WAIT_IMM;
          end
        end
        WAIT_IMM: begin
          if (i_in_valid) begin
            w_valid      = 1'b1;
            w_ctrl       = r_h_ctrl;
            w_mem_read   = r_h_mem_read;
            w_mem_write  = r_h_mem_write;
            w_write_back = r_h_write_back;
            w_imm        = 1'b1;
            w_data1      = r_h_data1;
            w_data2      = r_h_data2;
            w_rs         = r_h_rs;
            w_write_addr = r_h_write_addr;
            w_immediate  = i_fetch_word;
            w_state_nxt  = NORMAL;
          end
        end
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= NORMAL;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_h_ctrl       <= '0;
      r_h_mem_read   <= 1'b0;
      r_h_mem_write  <= 1'b0;
      r_h_write_back <= 1'b0;
      r_h_data1      <= '0;
      r_h_data2      <= '0;
      r_h_rs         <= '0;
      r_h_write_addr <= '0;
    end else if (w_cap_hold) begin
      r_h_ctrl       <= i_ctrl;
      r_h_mem_read   <= i_mem_read;
      r_h_mem_write  <= i_mem_write;
      r_h_write_back <= i_write_back;
      r_h_data1      <= i_data1;
      r_h_data2      <= i_data2;
      r_h_rs         <= i_rs;
      r_h_write_addr <= i_write_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_write_back <= 1'b0;
      r_imm        <= 1'b0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_rs         <= '0;
      r_write_addr <= '0;
      r_immediate  <= '0;
    end else if (w_load_out) begin
      r_valid      <= w_valid;
      r_ctrl       <= w_ctrl;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_write_back <= w_write_back;
      r_imm        <= w_imm;
      r_data1      <= w_data1;
      r_data2      <= w_data2;
      r_rs         <= w_rs;
      r_write_addr <= w_write_addr;
      r_immediate  <= w_immediate;
    end
  end

  assign o_valid      = r_valid;
  assign o_ctrl       = r_ctrl;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_write_back = r_write_back;
  assign o_imm        = r_imm;
  assign o_data1      = r_data1;
  assign o_data2      = r_data2;
  assign o_rs         = r_rs;
  assign o_write_addr = r_write_addr;
  assign o_immediate  = r_immediate;

endmodule

// File: tb/tb_idexm_buffer.sv
// Scoreboard bench for idexm_buffer: expected output vectors are queued when
// stimulus is driven and compared after the following clock edge.
module tb_idexm_buffer;
  typedef logic [82:0] vec_t;

  logic        clk, rst, flush, stall, in_valid;
  logic [23:0] ctrl;
  logic        mem_read, mem_write, write_back, imm;
  logic [15:0] data1, data2, fetch_word;
  logic [2:0]  rs, rt, write_addr;
  logic        rs_used, rt_used;
  logic        o_valid, o_mem_read, o_mem_write, o_write_back, o_imm, o_hold;
  logic [23:0] o_ctrl;
  logic [15:0] o_data1, o_data2, o_immediate;
  logic [2:0]  o_rs, o_write_addr;

  vec_t q[$];
  vec_t exp_v;
  int   n_cmp = 0;
  int   n_err = 0;

  idexm_buffer #(.CTRL_W(24), .DATA_W(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_stall(stall), .i_in_valid(in_valid),
    .i_ctrl(ctrl), .i_mem_read(mem_read), .i_mem_write(mem_write), .i_write_back(write_back),
    .i_imm(imm), .i_data1(data1), .i_data2(data2), .i_rs(rs), .i_rt(rt),
    .i_rs_used(rs_used), .i_rt_used(rt_used), .i_write_addr(write_addr), .i_fetch_word(fetch_word),
    .o_valid(o_valid), .o_ctrl(o_ctrl), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_write_back(o_write_back), .o_imm(o_imm), .o_data1(o_data1), .o_data2(o_data2),
    .o_rs(o_rs), .o_write_addr(o_write_addr), .o_immediate(o_immediate), .o_hold_upstream(o_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic v, input logic [23:0] c, input logic mr, input logic mw,
                              input logic wb, input logic im, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [2:0] r, input logic [2:0] wa,
                              input logic [15:0] immd);
    return {v, c, mr, mw, wb, im, d1, d2, r, wa, immd};
  endfunction

  function automatic vec_t dut_vec();
    return {o_valid, o_ctrl, o_mem_read, o_mem_write, o_write_back, o_imm,
            o_data1, o_data2, o_rs, o_write_addr, o_immediate};
  endfunction

  task automatic set_in(input logic v, input logic [23:0] c, input logic mr, input logic mw,
                        input logic wb, input logic im, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [2:0] r_s, input logic [2:0] r_t, input logic rsu, input logic rtu,
                        input logic [2:0] wa, input logic [15:0] fw);
    in_valid = v; ctrl = c; mem_read = mr; mem_write = mw; write_back = wb; imm = im;
    data1 = d1; data2 = d2; rs = r_s; rt = r_t; rs_used = rsu; rt_used = rtu;
    write_addr = wa; fetch_word = fw;
  endtask

  task automatic idle();
    set_in(0, 24'h0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 3'd0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: got %b expected 0", o_hold);
    end
    rst = 1'b0;
  endtask

  task automatic test_one_word();
    set_in(1, 24'h000011, 0, 0, 1, 0, 16'h0003, 16'h0004, 3'd0, 3'd1, 0, 0, 3'd2, 16'h0);
    q.push_back(mk(1, 24'h000011, 0, 0, 1, 0, 16'h0003, 16'h0004, 3'd0, 3'd2, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL one_word: got %h expected %h", dut_vec(), exp_v);
    end
    set_in(1, 24'h000022, 0, 1, 0, 0, 16'h00AA, 16'h0055, 3'd4, 3'd5, 1, 1, 3'd6, 16'h0);
    q.push_back(mk(1, 24'h000022, 0, 1, 0, 0, 16'h00AA, 16'h0055, 3'd4, 3'd6, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL one_word_store: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL idle_bubble: got %h expected %h", dut_vec(), exp_v);
    end
  endtask

  task automatic test_two_word();
    set_in(1, 24'h0000A5, 0, 0, 1, 1, 16'h1111, 16'h2222, 3'd1, 3'd2, 0, 0, 3'd5, 16'h0);
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL two_word_bubble: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL two_word_gap: got %h expected %h", dut_vec(), exp_v);
    end
    // other fields carry junk in the immediate cycle; the held opcode fields must win
    set_in(1, 24'hFFFFFF, 1, 1, 0, 0, 16'h9999, 16'h8888, 3'd5, 3'd5, 1, 1, 3'd7, 16'hBEEF);
    #1; n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL two_word_hold: got %b expected 0", o_hold);
    end
    q.push_back(mk(1, 24'h0000A5, 0, 0, 1, 1, 16'h1111, 16'h2222, 3'd1, 3'd5, 16'hBEEF));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL two_word_out: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
  endtask

  task automatic test_loaduse();
    set_in(1, 24'h00C001, 1, 0, 1, 0, 16'h0010, 16'h0000, 3'd1, 3'd0, 1, 0, 3'd3, 16'h0);
    q.push_back(mk(1, 24'h00C001, 1, 0, 1, 0, 16'h0010, 16'h0000, 3'd1, 3'd3, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL ldd_out: got %h expected %h", dut_vec(), exp_v);
    end
    set_in(1, 24'h000011, 0, 0, 1, 0, 16'h0007, 16'h0008, 3'd3, 3'd0, 1, 0, 3'd4, 16'h0);
    #1; n_cmp++;
    if (o_hold !== 1'b1) begin
      n_err++; $display("FAIL loaduse_hold: got %b expected 1", o_hold);
    end
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL loaduse_bubble: got %h expected %h", dut_vec(), exp_v);
    end
    n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL loaduse_hold_once: got %b expected 0", o_hold);
    end
    q.push_back(mk(1, 24'h000011, 0, 0, 1, 0, 16'h0007, 16'h0008, 3'd3, 3'd4, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL loaduse_add: got %h expected %h", dut_vec(), exp_v);
    end
    // load into r6 then a consumer reading r6 only through rt
    set_in(1, 24'h00C002, 1, 0, 1, 0, 16'h0020, 16'h0000, 3'd2, 3'd0, 1, 0, 3'd6, 16'h0);
    q.push_back(mk(1, 24'h00C002, 1, 0, 1, 0, 16'h0020, 16'h0000, 3'd2, 3'd6, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL ldd6_out: got %h expected %h", dut_vec(), exp_v);
    end
    set_in(1, 24'h000033, 0, 0, 1, 0, 16'h0001, 16'h0002, 3'd6, 3'd1, 0, 0, 3'd5, 16'h0);
    #1; n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL unused_match_hold: got %b expected 0", o_hold);
    end
    rt = 3'd6; rt_used = 1'b1; rs = 3'd1;
    #1; n_cmp++;
    if (o_hold !== 1'b1) begin
      n_err++; $display("FAIL rt_match_hold: got %b expected 1", o_hold);
    end
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL rt_bubble: got %h expected %h", dut_vec(), exp_v);
    end
    q.push_back(mk(1, 24'h000033, 0, 0, 1, 0, 16'h0001, 16'h0002, 3'd1, 3'd5, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL rt_add: got %h expected %h", dut_vec(), exp_v);
    end
    // non-dependent consumer after a load into r3
    set_in(1, 24'h00C001, 1, 0, 1, 0, 16'h0030, 16'h0000, 3'd0, 3'd0, 0, 0, 3'd3, 16'h0);
    q.push_back(mk(1, 24'h00C001, 1, 0, 1, 0, 16'h0030, 16'h0000, 3'd0, 3'd3, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL ldd3b_out: got %h expected %h", dut_vec(), exp_v);
    end
    set_in(1, 24'h000044, 0, 0, 1, 0, 16'h000B, 16'h000C, 3'd1, 3'd2, 1, 1, 3'd7, 16'h0);
    #1; n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL nodep_hold: got %b expected 0", o_hold);
    end
    q.push_back(mk(1, 24'h000044, 0, 0, 1, 0, 16'h000B, 16'h000C, 3'd1, 3'd7, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL nodep_add: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
  endtask

  task automatic test_flush();
    set_in(1, 24'h0000A6, 0, 0, 1, 1, 16'h0101, 16'h0202, 3'd1, 3'd2, 0, 0, 3'd4, 16'h0);
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL flush_enter_wait: got %h expected %h", dut_vec(), exp_v);
    end
    flush = 1'b1;
    set_in(1, 24'h0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 3'd0, 0, 0, 3'd0, 16'hCAFE);
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL flush_bubble: got %h expected %h", dut_vec(), exp_v);
    end
    flush = 1'b0;
    set_in(1, 24'h000055, 0, 0, 1, 0, 16'h1234, 16'h0009, 3'd2, 3'd3, 0, 0, 3'd1, 16'h1234);
    q.push_back(mk(1, 24'h000055, 0, 0, 1, 0, 16'h1234, 16'h0009, 3'd2, 3'd1, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL flush_then_opcode: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
  endtask

  task automatic test_stall();
    set_in(1, 24'h000066, 0, 0, 1, 0, 16'h0A0A, 16'h0B0B, 3'd3, 3'd4, 1, 1, 3'd5, 16'h0);
    q.push_back(mk(1, 24'h000066, 0, 0, 1, 0, 16'h0A0A, 16'h0B0B, 3'd3, 3'd5, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL stall_x: got %h expected %h", dut_vec(), exp_v);
    end
    stall = 1'b1;
    set_in(1, 24'h000077, 0, 0, 0, 0, 16'h0C0C, 16'h0D0D, 3'd6, 3'd7, 0, 0, 3'd1, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (o_hold !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %b expected 1", i, o_hold);
      end
      q.push_back(mk(1, 24'h000066, 0, 0, 1, 0, 16'h0A0A, 16'h0B0B, 3'd3, 3'd5, 16'h0));
      tick(); exp_v = q.pop_front(); n_cmp++;
      if (dut_vec() !== exp_v) begin
        n_err++; $display("FAIL stall_keep[%0d]: got %h expected %h", i, dut_vec(), exp_v);
      end
    end
    stall = 1'b0;
    q.push_back(mk(1, 24'h000077, 0, 0, 0, 0, 16'h0C0C, 16'h0D0D, 3'd6, 3'd1, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL stall_resume: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL stall_no_dup: got %h expected %h", dut_vec(), exp_v);
    end
  endtask

  task automatic test_flush_stall();
    set_in(1, 24'h000088, 1, 0, 1, 0, 16'h0E0E, 16'h0F0F, 3'd2, 3'd2, 0, 0, 3'd2, 16'h0);
    q.push_back(mk(1, 24'h000088, 1, 0, 1, 0, 16'h0E0E, 16'h0F0F, 3'd2, 3'd2, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL fs_x: got %h expected %h", dut_vec(), exp_v);
    end
    flush = 1'b1; stall = 1'b1;
    set_in(1, 24'h000099, 0, 0, 1, 0, 16'h0001, 16'h0001, 3'd2, 3'd2, 1, 1, 3'd3, 16'h0);
    #1; n_cmp++;
    if (o_hold !== 1'b0) begin
      n_err++; $display("FAIL fs_hold: got %b expected 0", o_hold);
    end
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL fs_bubble: got %h expected %h", dut_vec(), exp_v);
    end
    flush = 1'b0; stall = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    set_in(1, 24'h0000BB, 0, 0, 1, 0, 16'h0042, 16'h0043, 3'd1, 3'd1, 0, 0, 3'd7, 16'h0);
    q.push_back(mk(1, 24'h0000BB, 0, 0, 1, 0, 16'h0042, 16'h0043, 3'd1, 3'd7, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL rm_x: got %h expected %h", dut_vec(), exp_v);
    end
    #2 rst = 1'b1;
    #1; n_cmp++;
    if (dut_vec() !== '0) begin
      n_err++; $display("FAIL rm_async_clear: got %h expected 0", dut_vec());
    end
    rst = 1'b0;
    set_in(1, 24'h0000A7, 0, 0, 1, 1, 16'h5555, 16'h6666, 3'd2, 3'd3, 0, 0, 3'd6, 16'h0);
    q.push_back('0);
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL rm_enter_wait: got %h expected %h", dut_vec(), exp_v);
    end
    #2 rst = 1'b1;
    #1; n_cmp++;
    if (dut_vec() !== '0) begin
      n_err++; $display("FAIL rm_wait_clear: got %h expected 0", dut_vec());
    end
    rst = 1'b0;
    set_in(1, 24'h000011, 0, 0, 1, 0, 16'h0003, 16'h0004, 3'd0, 3'd1, 0, 0, 3'd2, 16'h7777);
    q.push_back(mk(1, 24'h000011, 0, 0, 1, 0, 16'h0003, 16'h0004, 3'd0, 3'd2, 16'h0));
    tick(); exp_v = q.pop_front(); n_cmp++;
    if (dut_vec() !== exp_v) begin
      n_err++; $display("FAIL rm_add_after: got %h expected %h", dut_vec(), exp_v);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_one_word();
    test_two_word();
    test_loaduse();
    test_flush();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
